// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unified_mem_arbiter: shares one byte-enabled word RAM between fetch & data  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module unified_mem_arbiter #(
   parameter int          ADDR_W     = 32,
   parameter int          RAM_AW     = 12,
   parameter int          RAM_LAT    = 1,
   parameter logic [31:0] IBASE      = 32'h3000,
   parameter int          STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_byteen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              busy
);
   localparam int                CNT_W   = $clog2(RAM_LAT + 1);
   localparam int                STV_W   = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] IBASE_A = ADDR_W'(IBASE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state;
   logic               sel_fetch;
   logic               is_write;
   logic [CNT_W-1:0]   wait_cnt;
   logic [STV_W-1:0]   starve;
   logic [ADDR_W-1:0]  fetch_off;
   logic [RAM_AW-1:0]  fetch_word;
   logic [RAM_AW-1:0]  data_word;
   logic               fetch_wins;
   logic               addr_unused;

   // Byte offsets beyond the RAM depth simply wrap; low two bits are ignored.
   assign fetch_off   = i_addr - IBASE_A;
   assign fetch_word  = fetch_off[RAM_AW+1:2];
   assign data_word   = d_addr[RAM_AW+1:2];
   assign addr_unused = ^{fetch_off, d_addr};

   // Data is older in the pipeline, so it wins unless fetch has starved long enough.
   assign fetch_wins = i_req && (!d_req || (starve == STV_W'(STARVE_MAX)));
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         sel_fetch  <= 1'b0;
         is_write   <= 1'b0;
         wait_cnt   <= '0;
         starve     <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_byteen <= '0;
         ram_wdata  <= '0;
      end else begin
         i_ack  <= 1'b0;
         d_ack  <= 1'b0;
         ram_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!i_req) starve <= '0;
               if (i_req || d_req) begin
                  state     <= S_ISSUE;
                  sel_fetch <= fetch_wins;
                  if (fetch_wins) begin
                     starve     <= '0;
                     is_write   <= 1'b0;
                     ram_en     <= 1'b1;
                     ram_we     <= 1'b0;
                     ram_addr   <= fetch_word;
                     ram_byteen <= '0;
                     ram_wdata  <= '0;
                  end else begin
                     if (i_req) starve <= starve + STV_W'(1);
                     is_write   <= d_we;
                     // An all-lanes-off store completes without touching the RAM.
                     ram_en     <= !(d_we && (d_byteen == 4'b0000));
                     ram_we     <= d_we;
                     ram_addr   <= data_word;
                     ram_byteen <= d_we ? d_byteen : 4'b0000;
                     ram_wdata  <= d_we ? d_wdata : 32'h0;
                  end
               end
            end
            S_ISSUE: begin
               if (is_write) begin
                  state <= S_RESP;
                  d_ack <= 1'b1;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= CNT_W'(RAM_LAT);
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
               if (wait_cnt == CNT_W'(1)) begin
                  state <= S_RESP;
                  if (sel_fetch) begin
                     i_rdata <= ram_rdata;
                     i_ack   <= 1'b1;
                  end else begin
                     d_rdata <= ram_rdata;
                     d_ack   <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire
